pp_seq_multiplier: RTL and testbench
====================================

PP_SEQ_MULTIPLIER -- requirements
Module: pp_seq_multiplier

Interface
REQ-001 Parameters: none; operand width is fixed at 8 bits and partial-product slice width at 2 bits.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 mode  input  1  0 = one 8x8 unsigned product; 1 = SIMD, two independent 4x4 unsigned lane products.
REQ-006 a  input  8  multiplicand, sampled with start.
REQ-007 b  input  8  multiplier, sampled with start.
REQ-008 mul_a  output  2  operand slice driven to the external 2-bit multiplier.
REQ-009 mul_b  output  2  operand slice driven to the external 2-bit multiplier.
REQ-010 mul_result  input  4  combinational product mul_a*mul_b returned by the 2-bit multiplier.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 product  output  16  result register; mode 0: full product; mode 1: lane1 in [15:8], lane0 in [7:0].

Function
REQ-014 FSM states: IDLE, RUN, DONE; no other states are reachable.
REQ-015 IDLE -> RUN on an edge where start=1; on that edge a, b, mode are latched, the step counter k is cleared to 0, and the internal accumulator is cleared to 0.
REQ-016 start in RUN or DONE is ignored; latched operands are unaffected by input changes after acceptance.
REQ-017 Mode 0: 16 steps, k=0..15; i=k[1:0], j=k[3:2]; mul_a=a_lat[2i+1:2i], mul_b=b_lat[2j+1:2j]; term = mul_result << 2(i+j).
REQ-018 Mode 1: 8 steps, k=0..7; lane L=k[2], i=k[0], j=k[1]; mul_a=a_lat[4L+2i+1:4L+2i], mul_b=b_lat[4L+2j+1:4L+2j]; term = mul_result << (8L+2(i+j)).
REQ-019 Mode 1 lanes never exchange carries; every lane sum is at most 225 and fits 8 bits.
REQ-020 On every RUN edge: accumulator += term (16-bit, no overflow possible) and k increments.
REQ-021 On the final-step edge (k=15 for mode 0, k=7 for mode 1): product is loaded with accumulator+term, state -> DONE.
REQ-022 DONE lasts exactly one cycle, then -> IDLE unconditionally; done=1 only in DONE.
REQ-023 Latency: with start sampled at edge 0, done is high after edge 16 (mode 0) or edge 8 (mode 1), and low again after the following edge.
REQ-024 mul_a and mul_b are driven from registered state only (no combinational path from start/a/b); both are 0 outside RUN.
REQ-025 product holds its value until the next completion; it does not change at start acceptance.
REQ-026 Back-to-back: a start high during DONE is dropped; the earliest next acceptance is in the IDLE cycle that follows.

Reset
REQ-027 nrst=0 asynchronously forces IDLE, k=0, accumulator=0, product=0x0000, busy=0, done=0, mul_a=0, mul_b=0, and latched a/b/mode to 0.
REQ-028 Reset asserted mid-RUN aborts the operation with no done pulse; after release the block is in IDLE and accepts a new start.

Verification
REQ-029 Mode 0, a=0xFF, b=0xFF, start pulse -> busy for 16 cycles, done after edge 16, product=0xFE01.
REQ-030 Mode 0, a=0xA5, b=0x3C -> product=0x26AC; mode 0, a=0x00, b=0xFF -> product=0x0000.
REQ-031 Mode 1, a=0xFF, b=0xFF -> done after edge 8, product=0xE1E1; mode 1, a=0x3C, b=0x05 -> product=0x003C (lane1 3*0, lane0 12*5).
REQ-032 Start re-pulsed with new operands during RUN and during DONE -> ignored; product equals the first operation's result; one done pulse only.
REQ-033 nrst pulsed low at step k=5 of a mode 0 run -> all outputs 0 immediately, no done pulse; a fresh start with a=0x02, b=0x03 -> product=0x0006.
REQ-034 Bench instantiates a 2x2 multiplier on mul_a/mul_b/mul_result and checks every step's mul_a/mul_b against the REQ-017/REQ-018 ordering.

Source files
------------

// File: rtl/pp_seq_multiplier_if.sv
// Bundles the request and external 2x2 multiplier signals of the sequential partial-product multiplier.
// The slave side is the multiplier core; the master side is the requester and the external 2-bit multiplier.
interface pp_seq_multiplier_if;
  logic        start;
  logic        mode;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [1:0]  mul_a;
  logic [1:0]  mul_b;
  logic [3:0]  mul_result;
  logic        busy;
  logic        done;
  logic [15:0] product;

  modport master (
    output start, mode, a, b, mul_result,
    input  mul_a, mul_b, busy, done, product
  );

  modport slave (
    input  start, mode, a, b, mul_result,
    output mul_a, mul_b, busy, done, product
  );
endinterface

// File: rtl/pp_seq_multiplier.sv
// Sequential 8x8 (or dual 4x4 SIMD) unsigned multiplier that feeds 2-bit operand slices to an
// external 2x2 multiplier and accumulates shifted partial products over 16 (or 8) steps.
module pp_seq_multiplier (
  input  logic                CLK,
  input  logic                nrst,
  pp_seq_multiplier_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions of the two operand slices and the shift of the resulting partial product.
  typedef struct packed {
    logic [2:0] pos_a;
    logic [2:0] pos_b;
    logic [3:0] shift;
  } step_t;

  function automatic step_t step_pos(input logic md, input logic [3:0] k);
    step_t s;
    if (!md) begin
      s.pos_a = {k[1:0], 1'b0};
      s.pos_b = {k[3:2], 1'b0};
      s.shift = {1'b0, s.pos_a} + {1'b0, s.pos_b};
    end else begin
      // k[2] selects the lane; the lane offset of 4 bits on the operands becomes 8 on the product.
      s.pos_a = {k[2], k[0], 1'b0};
      s.pos_b = {k[2], k[1], 1'b0};
      s.shift = {k[2], 3'b000} + {2'b00, k[0], 1'b0} + {2'b00, k[1], 1'b0};
    end
    return s;
  endfunction

  state_t      state_reg;
  logic [3:0]  k_reg;
  logic [15:0] acc_reg;
  logic [15:0] product_reg;
  logic [7:0]  a_reg;
  logic [7:0]  b_reg;
  logic        mode_reg;
  logic [1:0]  mul_a_reg;
  logic [1:0]  mul_b_reg;
  logic        busy_reg;
  logic        done_reg;

  step_t       cur_step;
  step_t       nxt_step;
  step_t       first_step;
  logic [3:0]  k_next;
  logic [15:0] term;
  logic [15:0] acc_next;
  logic        last_step;

  always_comb begin
    k_next     = k_reg + 4'd1;
    cur_step   = step_pos(mode_reg, k_reg);
    nxt_step   = step_pos(mode_reg, k_next);
    first_step = step_pos(bus.mode, 4'd0);
    term       = {12'd0, bus.mul_result} << cur_step.shift;
    acc_next   = acc_reg + term;
    last_step  = mode_reg ? (k_reg == 4'd7) : (k_reg == 4'd15);
  end

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state_reg   <= IDLE;
      k_reg       <= 4'd0;
      acc_reg     <= 16'd0;
      product_reg <= 16'd0;
      a_reg       <= 8'd0;
      b_reg       <= 8'd0;
      mode_reg    <= 1'b0;
      mul_a_reg   <= 2'd0;
      mul_b_reg   <= 2'd0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            state_reg <= RUN;
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            mode_reg  <= bus.mode;
            k_reg     <= 4'd0;
            acc_reg   <= 16'd0;
            // Slices for step 0 are registered here so the first RUN cycle already presents them.
            mul_a_reg <= bus.a[first_step.pos_a +: 2];
            mul_b_reg <= bus.b[first_step.pos_b +: 2];
            busy_reg  <= 1'b1;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          k_reg   <= k_next;
          if (last_step) begin
            state_reg   <= DONE;
            product_reg <= acc_next;
            mul_a_reg   <= 2'd0;
            mul_b_reg   <= 2'd0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
          end else begin
            mul_a_reg <= a_reg[nxt_step.pos_a +: 2];
            mul_b_reg <= b_reg[nxt_step.pos_b +: 2];
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          mul_a_reg <= 2'd0;
          mul_b_reg <= 2'd0;
        end
      endcase
    end
  end

  assign bus.mul_a   = mul_a_reg;
  assign bus.mul_b   = mul_b_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.product = product_reg;

endmodule

// File: tb/tb_pp_seq_multiplier.sv
// Randomized and directed bench for pp_seq_multiplier against an arithmetic product model,
// with a 2x2 multiplier attached to the slice outputs.
module tb_pp_seq_multiplier;

  logic clk;
  logic nrst;
  int   checks;
  int   failures;
  logic [15:0] prev_product;

  pp_seq_multiplier_if bus();

  pp_seq_multiplier dut (
    .CLK  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  assign bus.mul_result = bus.mul_a * bus.mul_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_product(input bit md, input logic [7:0] x, input logic [7:0] y);
    int hi;
    int lo;
    if (!md) return 16'(int'(x) * int'(y));
    hi = int'(x[7:4]) * int'(y[7:4]);
    lo = int'(x[3:0]) * int'(y[3:0]);
    return 16'(hi * 256 + lo);
  endfunction

  // Expected operand slices for step s, taken straight from the step ordering rules.
  function automatic logic [3:0] model_slices(input bit md, input int s, input logic [7:0] x, input logic [7:0] y);
    int i;
    int j;
    int l;
    int ea;
    int eb;
    if (!md) begin
      i  = s % 4;
      j  = s / 4;
      ea = (int'(x) >> (2 * i)) & 3;
      eb = (int'(y) >> (2 * j)) & 3;
    end else begin
      l  = s / 4;
      i  = s % 2;
      j  = (s / 2) % 2;
      ea = (int'(x) >> (4 * l + 2 * i)) & 3;
      eb = (int'(y) >> (4 * l + 2 * j)) & 3;
    end
    return {2'(ea), 2'(eb)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input bit md, input logic [7:0] x, input logic [7:0] y, input bit repulse);
    int n;
    int done_seen;
    logic [15:0] exp;
    logic [3:0]  sl;
    n   = md ? 8 : 16;
    exp = model_product(md, x, y);
    done_seen = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = md;
    bus.a     = x;
    bus.b     = y;
    tick();
    bus.start = 1'b0;
    check_eq("product_hold_at_accept", {16'd0, bus.product}, {16'd0, prev_product});
    for (int s = 0; s < n; s++) begin
      sl = model_slices(md, s, x, y);
      check_eq("busy_run", {31'd0, bus.busy}, 32'd1);
      check_eq("mul_a_step", {30'd0, bus.mul_a}, {30'd0, sl[3:2]});
      check_eq("mul_b_step", {30'd0, bus.mul_b}, {30'd0, sl[1:0]});
      if (bus.done) done_seen++;
      if (repulse && s == 3) begin
        bus.start = 1'b1;
        bus.mode  = ~md;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    check_eq("early_done", done_seen, 0);
    check_eq("done_pulse", {31'd0, bus.done}, 32'd1);
    check_eq("busy_done", {31'd0, bus.busy}, 32'd0);
    check_eq("product", {16'd0, bus.product}, {16'd0, exp});
    check_eq("mul_idle", {28'd0, bus.mul_a, bus.mul_b}, 32'd0);
    if (repulse) begin
      bus.start = 1'b1;
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
    end
    tick();
    bus.start = 1'b0;
    check_eq("done_low", {31'd0, bus.done}, 32'd0);
    check_eq("busy_after", {31'd0, bus.busy}, 32'd0);
    check_eq("product_kept", {16'd0, bus.product}, {16'd0, exp});
    prev_product = exp;
    $display("op mode=%0d a=0x%02h b=0x%02h repulse=%0d product=0x%04h expected=0x%04h",
             md, x, y, repulse, bus.product, exp);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    prev_product = 16'd0;
    nrst      = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.a     = 8'd0;
    bus.b     = 8'd0;
    #12;
    check_eq("reset_product", {16'd0, bus.product}, 32'd0);
    check_eq("reset_flags", {30'd0, bus.busy, bus.done}, 32'd0);
    check_eq("reset_mul", {28'd0, bus.mul_a, bus.mul_b}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    tick();

    do_op(1'b0, 8'hFF, 8'hFF, 1'b0);
    do_op(1'b0, 8'hA5, 8'h3C, 1'b0);
    do_op(1'b0, 8'h00, 8'hFF, 1'b0);
    do_op(1'b1, 8'hFF, 8'hFF, 1'b0);
    do_op(1'b1, 8'h3C, 8'h05, 1'b0);
    do_op(1'b0, 8'h5A, 8'hC3, 1'b1);
    do_op(1'b1, 8'h9E, 8'h7B, 1'b1);

    // Abort a mode 0 run at step 5 with an asynchronous reset.
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    tick();
    bus.start = 1'b0;
    for (int s = 0; s < 5; s++) tick();
    #2;
    nrst = 1'b0;
    #1;
    check_eq("abort_product", {16'd0, bus.product}, 32'd0);
    check_eq("abort_flags", {30'd0, bus.busy, bus.done}, 32'd0);
    check_eq("abort_mul", {28'd0, bus.mul_a, bus.mul_b}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    prev_product = 16'd0;
    for (int s = 0; s < 20; s++) begin
      tick();
      check_eq("abort_no_done", {31'd0, bus.done}, 32'd0);
    end
    do_op(1'b0, 8'h02, 8'h03, 1'b0);

    for (int t = 0; t < 24; t++) begin
      do_op(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
